watch_scan_ctrl: RTL
====================

WATCH_SCAN_CTRL -- requirements
Module: watch_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000, meaning clock cycles each digit is driven (legal range >=1).
REQ-002 SHALL have parameter GUARD_CYC, default 2, meaning all-digits-off dead cycles between digits (legal range >=1).
REQ-003 SHALL have parameter BLINK_DIV, default 250000, meaning clock cycles per blink half-period (legal range >=1).
REQ-004 SHALL have one clock and synchronous active-high reset: CLK input 1 (rising-edge clock), RESET input 1 (synchronous, active-high).
REQ-005 SHALL have port HOUR, input, 7 bits: binary hour value.
REQ-006 SHALL have port MIN, input, 7 bits: binary minute value.
REQ-007 SHALL have port SEC, input, 7 bits: binary second value.
REQ-008 SHALL have port BLINK_SEL, input, 2 bits: blinking field, where 00 = none, 01 = hour, 10 = min, 11 = sec.
REQ-009 SHALL have port LZB, input, 1 bit: 1 blanks the hour tens digit when it is 0.
REQ-010 SHALL have port DIGIT_SEL, output, 6 bits: one-hot, active-high digit enable.
REQ-011 SHALL have port SEG, output, 7 bits: {g,f,e,d,c,b,a}, active-high segments.
REQ-012 SHALL have port DP, output, 1 bit: colon/decimal point, active-high.

Function
REQ-013 SHALL scan digit index 0..5 in this order: 0 hour tens, 1 hour ones, 2 min tens, 3 min ones, 4 sec tens, 5 sec ones.
- Index wraps 5 -> 0.
- DIGIT_SEL[idx] is the bit that asserts for index idx.
REQ-014 SHALL implement a two-state FSM (GUARD, DRIVE), with transitions:
- GUARD lasts exactly GUARD_CYC cycles, then goes to DRIVE.
- DRIVE lasts exactly SCAN_DIV cycles, then goes to GUARD with idx+1 mod 6.
- One digit period = GUARD_CYC+SCAN_DIV cycles; one frame = 6 digit periods.
REQ-015 SHALL hold DIGIT_SEL, SEG and DP at 0 in GUARD.
- In DRIVE, DIGIT_SEL, SEG and DP are registered and change in the same cycle.
- No cycle shows a new DIGIT_SEL with stale SEG.
REQ-016 SHALL snapshot HOUR, MIN and SEC into internal registers on the last GUARD cycle before idx 0 enters DRIVE.
- All six digits of a frame come from one snapshot.
- Input changes mid-frame appear only in the next frame.
REQ-017 SHALL split each snapshot value into tens and ones digits, with these rules:
- Value 0..99: tens = value/10, ones = value mod 10.
- Value >99: both digits = 0.
REQ-018 SHALL encode digits with this table:
- 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66
- 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F
REQ-019 SHALL force SEG=0 at idx 0 when LZB=1 and the hour tens digit is 0; DIGIT_SEL still asserts.
REQ-020 SHALL assert DP during DRIVE at idx 1 and 3 only.
REQ-021 SHALL run a free-running blink counter with these rules:
- The phase toggles every BLINK_DIV cycles.
- After reset the phase starts "on".
- In the "off" phase, the two digits of the field chosen by BLINK_SEL output SEG=0 and DP=0; DIGIT_SEL still scans.
REQ-022 SHALL sample BLINK_SEL and LZB every cycle; they are not snapshotted.
REQ-023 SHALL use counter widths sufficient for the parameter values, with no overflow at legal parameter values.

Reset
REQ-024 SHALL, on RESET=1 at a CLK edge, set state GUARD, idx 0, the guard/drive counter to 0, the blink counter to 0 with phase "on", and snapshot registers to 0.
REQ-025 SHALL drive DIGIT_SEL=0, SEG=0 and DP=0 from the first edge with RESET=1 until the first DRIVE cycle after release.
REQ-026 SHALL abort the current frame on RESET asserted mid-DRIVE; after release the scan restarts at idx 0 with a full GUARD_CYC.

Structure
REQ-027 SHALL place the 7-segment table constants, BLINK_SEL encodings and FSM state encodings in a shared watch package.
REQ-028 SHALL instantiate one sub-module, watch_sep: combinational 7-bit binary -> 4-bit tens/ones, with out-of-range values giving 0/0.
- The single instance is time-shared, fed by a mux of snapshot registers selected by idx.

Verification
REQ-029 SHALL cover reset: with SCAN_DIV=4, GUARD_CYC=1, release RESET.
- Outputs are 0 for 1 cycle.
- Then DIGIT_SEL=000001 for 4 cycles.
- Then 0 for 1 cycle.
- Then 000010.
REQ-030 SHALL cover a normal frame: with HOUR=12, MIN=34, SEC=56, LZB=0, BLINK_SEL=00.
- SEG per idx 0..5 = 0x06, 0x5B, 0x4F, 0x66, 0x6D, 0x7D.
- DP=1 only at idx 1 and 3.
- Frame length = 30 cycles.
REQ-031 SHALL cover snapshot behaviour: change MIN 34 -> 35 while idx=2.
- idx 3 shows 0x66 in the current frame.
- idx 3 shows 0x6D in the next frame.
REQ-032 SHALL cover blanking and range:
- HOUR=7, LZB=1 -> idx0 SEG=0, idx1 0x07.
- HOUR=120, LZB=0 -> idx0 and idx1 both 0x3F.
REQ-033 SHALL cover blink: BLINK_SEL=10, BLINK_DIV=30.
- In alternate 30-cycle windows, idx 2 and 3 show SEG=0 and DP=0.
- DIGIT_SEL keeps scanning; other digits are unaffected.
REQ-034 SHALL cover reset mid-operation: assert RESET for 1 cycle during DRIVE at idx 4.
- Outputs are 0 on the next cycle.
- The scan restarts at idx 0 after GUARD_CYC cycles.

Source files
------------

// File: rtl/watch_scan_ctrl_pkg.sv
// Shared constants for the multiplexed watch display scanner:
// segment patterns, blink field codes and scan FSM states.
package watch_scan_ctrl_pkg;

    localparam int NUM_DIGITS = 6;

    typedef enum logic {
        ST_GUARD = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_e;

    typedef enum logic [1:0] {
        BLINK_NONE = 2'b00,
        BLINK_HOUR = 2'b01,
        BLINK_MIN  = 2'b10,
        BLINK_SEC  = 2'b11
    } blink_sel_e;

    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;

    function automatic logic [6:0] seg_encode(logic [3:0] d);
        logic [6:0] s;
        s = 7'h00;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/watch_sep.sv
// Binary to tens/ones splitter; values above 99 read as 00.
module watch_sep
    import watch_scan_ctrl_pkg::*;
(
    input  logic [6:0] bin_i,
    output logic [3:0] tens_o,
    output logic [3:0] ones_o
);

    always_comb begin
        tens_o = 4'd0;
        ones_o = 4'd0;
        if (bin_i <= 7'd99) begin
            tens_o = 4'(bin_i / 7'd10);
            ones_o = 4'(bin_i % 7'd10);
        end
    end

endmodule

// File: rtl/watch_scan_ctrl.sv
// Six-digit HH:MM:SS display scanner with dead-time guard,
// per-frame input snapshot, leading-zero blanking and field blink.
module watch_scan_ctrl
    import watch_scan_ctrl_pkg::*;
#(
    parameter int SCAN_DIV  = 1000,
    parameter int GUARD_CYC = 2,
    parameter int BLINK_DIV = 250000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [6:0] HOUR,
    input  logic [6:0] MIN,
    input  logic [6:0] SEC,
    input  logic [1:0] BLINK_SEL,
    input  logic       LZB,
    output logic [5:0] DIGIT_SEL,
    output logic [6:0] SEG,
    output logic       DP
);

    localparam int CNT_MAX = (SCAN_DIV > GUARD_CYC) ? SCAN_DIV : GUARD_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int BW      = $clog2(BLINK_DIV + 1);

    scan_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [6:0]    hour_q, hour_d;
    logic [6:0]    min_q, min_d;
    logic [6:0]    sec_q, sec_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          phase_q, phase_d;
    logic [5:0]    digit_sel_q, digit_sel_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;

    logic       take;
    logic       blank;
    logic [6:0] sep_bin;
    logic [3:0] sep_tens;
    logic [3:0] sep_ones;
    logic [3:0] digit;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        idx_d   = idx_q;
        take    = 1'b0;
        unique case (state_q)
            ST_GUARD: begin
                if (cnt_q == CW'(GUARD_CYC - 1)) begin
                    state_d = ST_DRIVE;
                    cnt_d   = '0;
                    take    = (idx_q == 3'd0);
                end
            end
            ST_DRIVE: begin
                if (cnt_q == CW'(SCAN_DIV - 1)) begin
                    state_d = ST_GUARD;
                    cnt_d   = '0;
                    idx_d   = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
                end
            end
            default: begin
                state_d = ST_GUARD;
                cnt_d   = '0;
            end
        endcase
    end

    // Snapshot bypass lets idx 0 show the freshly captured hour at once.
    assign hour_d = take ? HOUR : hour_q;
    assign min_d  = take ? MIN  : min_q;
    assign sec_d  = take ? SEC  : sec_q;

    always_comb begin
        bcnt_d  = bcnt_q + BW'(1);
        phase_d = phase_q;
        if (bcnt_q == BW'(BLINK_DIV - 1)) begin
            bcnt_d  = '0;
            phase_d = ~phase_q;
        end
    end

    always_comb begin
        unique case (idx_d[2:1])
            2'd0:    sep_bin = hour_d;
            2'd1:    sep_bin = min_d;
            default: sep_bin = sec_d;
        endcase
    end

    watch_sep u_sep (
        .bin_i  (sep_bin),
        .tens_o (sep_tens),
        .ones_o (sep_ones)
    );

    assign digit = idx_d[0] ? sep_ones : sep_tens;

    always_comb begin
        blank = 1'b0;
        if (!phase_d) begin
            unique case (blink_sel_e'(BLINK_SEL))
                BLINK_HOUR: blank = (idx_d[2:1] == 2'd0);
                BLINK_MIN:  blank = (idx_d[2:1] == 2'd1);
                BLINK_SEC:  blank = (idx_d[2:1] == 2'd2);
                default:    blank = 1'b0;
            endcase
        end
    end

    // Outputs are built from next-state so they line up with DRIVE.
    always_comb begin
        digit_sel_d = 6'd0;
        seg_d       = 7'd0;
        dp_d        = 1'b0;
        if (state_d == ST_DRIVE) begin
            digit_sel_d = 6'd1 << idx_d;
            seg_d       = seg_encode(digit);
            dp_d        = (idx_d == 3'd1) || (idx_d == 3'd3);
            if (idx_d == 3'd0 && LZB && sep_tens == 4'd0) begin
                seg_d = 7'd0;
            end
            if (blank) begin
                seg_d = 7'd0;
                dp_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= ST_GUARD;
            cnt_q       <= '0;
            idx_q       <= 3'd0;
            hour_q      <= 7'd0;
            min_q       <= 7'd0;
            sec_q       <= 7'd0;
            bcnt_q      <= '0;
            phase_q     <= 1'b1;
            digit_sel_q <= 6'd0;
            seg_q       <= 7'd0;
            dp_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            hour_q      <= hour_d;
            min_q       <= min_d;
            sec_q       <= sec_d;
            bcnt_q      <= bcnt_d;
            phase_q     <= phase_d;
            digit_sel_q <= digit_sel_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
        end
    end

    assign DIGIT_SEL = digit_sel_q;
    assign SEG       = seg_q;
    assign DP        = dp_q;

endmodule
